// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and the illegal-op check for alu_pipe_hs.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_NOT = 4'b0100;
   localparam logic [3:0] OP_MUL = 4'b0101;
   localparam logic [3:0] OP_SLT = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;
   localparam logic [3:0] OP_SRA = 4'b1000;
   localparam logic [3:0] OP_SRL = 4'b1001;
   localparam logic [3:0] OP_SLL = 4'b1010;
   localparam logic [3:0] OP_ROL = 4'b1100;
   localparam logic [3:0] OP_ROR = 4'b1101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // MUL is only legal when the iterative multiplier is built in.
   function automatic logic op_illegal(input logic [3:0] op, input logic mul_en);
      return (op == 4'b1011) || (op == 4'b1110) || (op == 4'b1111) ||
             ((op == OP_MUL) && !mul_en);
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier, one multiplier bit per cycle; returns the low WIDTH bits of the product.
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;

   // done marks the cycle whose edge applies the final multiplier bit
   assign done = busy && (cnt == '0);
   assign prod = acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (start && !busy) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         cnt    <= CW'(WIDTH - 1);
         busy   <= 1'b1;
      end else if (busy) begin
         if (mplier[0])
            acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (cnt == '0)
            busy <= 1'b0;
         else
            cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/alu_pipe_hs.sv
// ALU with registered result stage, valid/ready handshakes and an optional iterative multiply.
//  state  | meaning
//  S_IDLE | accepting ops; single-cycle results registered on accept
//  S_MUL  | multiplier iterating, input side stalled
//  S_DONE | product written to the output register, back to S_IDLE next
module alu_pipe_hs
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             carry,
   output logic             ovf,
   output logic             op_err
);

   localparam int SW = $clog2(WIDTH);

   state_t state;

   logic [SW-1:0]      sh;
   logic [WIDTH:0]     sum_add;
   logic [WIDTH:0]     sum_sub;
   logic [2*WIDTH-1:0] rol_w;
   logic [2*WIDTH-1:0] ror_w;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;
   logic               illegal;
   logic               is_mul;
   logic               accept;
   logic               mul_busy;
   logic               mul_done;
   logic [WIDTH-1:0]   mul_prod;

   assign in_ready = (state == S_IDLE) && !mul_busy && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign illegal  = op_illegal(op, MUL_EN != 0);
   assign is_mul   = (op == OP_MUL) && (MUL_EN != 0);

   assign sh      = b[SW-1:0];
   assign sum_add = {1'b0, a} + {1'b0, b};
   assign sum_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
   assign rol_w   = {a, a} << sh;
   assign ror_w   = {a, a} >> sh;

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = sum_add[WIDTH-1:0];
            alu_c   = sum_add[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = sum_sub[WIDTH-1:0];
            alu_c   = sum_sub[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_NOT:  alu_res = ~a;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_XOR:  alu_res = a ^ b;
         OP_SRA:  alu_res = WIDTH'($signed(a) >>> sh);
         OP_SRL:  alu_res = a >> sh;
         OP_SLL:  alu_res = a << sh;
         OP_ROL:  alu_res = rol_w[2*WIDTH-1:WIDTH];
         OP_ROR:  alu_res = ror_w[WIDTH-1:0];
         default: alu_res = '0;
      endcase
   end

   generate
      if (MUL_EN != 0) begin : g_mul
         alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
            .clk   (clk),
            .rst_n (rst_n),
            .start (accept && is_mul),
            .a     (a),
            .b     (b),
            .busy  (mul_busy),
            .done  (mul_done),
            .prod  (mul_prod)
         );
      end else begin : g_no_mul
         assign mul_busy = 1'b0;
         assign mul_done = 1'b0;
         assign mul_prod = '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         out       <= '0;
         zero      <= 1'b1;
         carry     <= 1'b0;
         ovf       <= 1'b0;
         op_err    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept && is_mul) begin
                  state     <= S_MUL;
                  out_valid <= 1'b0;
               end else if (accept) begin
                  out       <= alu_res;
                  zero      <= (alu_res == '0);
                  carry     <= alu_c;
                  ovf       <= alu_v;
                  op_err    <= illegal;
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            S_MUL: begin
               if (mul_done)
                  state <= S_DONE;
            end
            S_DONE: begin
               out       <= mul_prod;
               zero      <= (mul_prod == '0);
               carry     <= 1'b0;
               ovf       <= 1'b0;
               op_err    <= 1'b0;
               out_valid <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Scoreboard bench for alu_pipe_hs: directed vectors, handshake corner cases, random ops.
module tb_alu_pipe_hs;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [3:0]    op;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out;
   logic          zero;
   logic          carry;
   logic          ovf;
   logic          op_err;

   typedef struct packed {
      logic [31:0] r;
      logic        z;
      logic        c;
      logic        v;
      logic        e;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad = 0;
   int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

   alu_pipe_hs #(.WIDTH(W), .MUL_EN(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .zero      (zero),
      .carry     (carry),
      .ovf       (ovf),
      .op_err    (op_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] r, input logic c, input logic v, input logic e);
      exp_t x;
      x.r = r; x.z = (r == 32'd0); x.c = c; x.v = v; x.e = e;
      return x;
   endfunction

   // Reference: plain arithmetic on 64-bit values and one-bit-at-a-time shifts.
   function automatic exp_t model(input logic [31:0] a_, input logic [31:0] b_, input logic [3:0] op_);
      bit [63:0]   u;
      longint      s;
      logic [31:0] r;
      logic        c, v, e;
      int          amt;
      r = 32'd0; c = 1'b0; v = 1'b0; e = 1'b0;
      amt = int'(b_ % 32);
      case (op_)
         4'h0: begin
            u = {32'd0, a_} + {32'd0, b_};
            r = u[31:0]; c = u[32];
            s = longint'($signed(a_)) + longint'($signed(b_));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'h1: begin
            r = a_ - b_; c = (a_ >= b_);
            s = longint'($signed(a_)) - longint'($signed(b_));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'h2: r = a_ & b_;
         4'h3: r = a_ | b_;
         4'h4: r = ~a_;
         4'h5: begin u = {32'd0, a_} * {32'd0, b_}; r = u[31:0]; end
         4'h6: r = ($signed(a_) < $signed(b_)) ? 32'd1 : 32'd0;
         4'h7: r = a_ ^ b_;
         4'h8: begin r = a_; repeat (amt) r = {r[31], r[31:1]}; end
         4'h9: begin r = a_; repeat (amt) r = {1'b0, r[31:1]}; end
         4'hA: begin r = a_; repeat (amt) r = {r[30:0], 1'b0}; end
         4'hC: begin r = a_; repeat (amt) r = {r[30:0], r[31]}; end
         4'hD: begin r = a_; repeat (amt) r = {r[0], r[31:1]}; end
         default: e = 1'b1;
      endcase
      return mk(r, c, v, e);
   endfunction

   task automatic send_exp(input logic [31:0] av, input logic [31:0] bv, input logic [3:0] opv, input exp_t e);
      int n;
      @(negedge clk);
      a = av; b = bv; op = opv; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL accept_timeout actual=in_ready_low expected=accept op=%h", opv);
         in_valid = 1'b0;
         return;
      end
      sbq.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [3:0] opv);
      send_exp(av, bv, opv, model(av, bv, opv));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            2:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pops on each output transfer; also checks hold stability under backpressure.
   initial begin
      exp_t e;
      exp_t hv;
      logic held;
      held = 1'b0;
      hv = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held = 1'b0;
         end else begin
            if (held) begin
               chk("hold_valid", 32'(out_valid), 32'd1);
               chk("hold_out", out, hv.r);
               chk("hold_flags", {28'd0, zero, carry, ovf, op_err}, {28'd0, hv.z, hv.c, hv.v, hv.e});
            end
            if (out_valid && out_ready) begin
               if (sbq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL spurious_result actual=%h expected=no_result", out);
               end else begin
                  e = sbq.pop_front();
                  chk("out", out, e.r);
                  chk("zero", 32'(zero), 32'(e.z));
                  chk("carry", 32'(carry), 32'(e.c));
                  chk("ovf", 32'(ovf), 32'(e.v));
                  chk("op_err", 32'(op_err), 32'(e.e));
               end
            end
            held = out_valid && !out_ready;
            hv.r = out; hv.z = zero; hv.c = carry; hv.v = ovf; hv.e = op_err;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] av, bv;
      logic [3:0]  opv;

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out", out, 32'd0);
      chk("rst_flags", {28'd0, zero, carry, ovf, op_err}, 32'h8);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;

      send_exp(32'hFFFF_FFFF, 32'h1, 4'h0, mk(32'h0, 1'b1, 1'b0, 1'b0));
      @(negedge clk);
      chk("add_next_cycle_valid", 32'(out_valid), 32'd1);
      send_exp(32'h8000_0000, 32'h1, 4'h1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
      send_exp(32'h8000_0000, 32'h4, 4'h8, mk(32'hF800_0000, 1'b0, 1'b0, 1'b0));
      send_exp(32'h1, 32'h1, 4'hD, mk(32'h8000_0000, 1'b0, 1'b0, 1'b0));
      send_exp(32'h1, 32'd32, 4'hA, mk(32'h1, 1'b0, 1'b0, 1'b0));
      send_exp(32'h1234, 32'h5678, 4'hF, mk(32'h0, 1'b0, 1'b0, 1'b1));
      send_exp(32'h3, 32'h5, 4'h7, mk(32'h6, 1'b0, 1'b0, 1'b0));
      send_exp(32'hFFFF_FFFF, 32'h1, 4'h6, mk(32'h1, 1'b0, 1'b0, 1'b0));
      wait_drain();

      // Multiply: stall length and final product
      send_exp(32'd1000000, 32'd1000000, 4'h5, mk(32'hD4A5_1000, 1'b0, 1'b0, 1'b0));
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("mul_stall_cycles", 32'(n), 32'd33);
      chk("mul_out_valid", 32'(out_valid), 32'd1);
      wait_drain();

      // Backpressure then drain + accept in the same cycle
      rdy_mode = 2;
      @(posedge clk); #2;
      send_exp(32'h10, 32'h20, 4'h0, mk(32'h30, 1'b0, 1'b0, 1'b0));
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out", out, 32'h30);
      end
      rdy_mode = 0;
      send_exp(32'h0F, 32'hF0, 4'h3, mk(32'hFF, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      chk("no_bubble_valid", 32'(out_valid), 32'd1);
      chk("no_bubble_out", out, 32'hFF);
      wait_drain();

      // Reset in the middle of a multiply
      send_exp(32'd7, 32'd9, 4'h5, mk(32'd63, 1'b0, 1'b0, 1'b0));
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      chk("abort_pending", 32'(sbq.size()), 32'd1);
      sbq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      n = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) n++;
      end
      chk("no_late_result", 32'(n), 32'd0);

      // Random traffic with random backpressure
      rdy_mode = 1;
      for (int i = 0; i < 400; i++) begin
         opv = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 5))
            0:       av = 32'h0;
            1:       av = 32'hFFFF_FFFF;
            2:       av = 32'h8000_0000;
            3:       av = 32'h7FFF_FFFF;
            default: av = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       bv = 32'h1;
            1:       bv = 32'hFFFF_FFFF;
            2:       bv = 32'h8000_0000;
            3:       bv = 32'($urandom_range(0, 40));
            default: bv = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0)
            @(negedge clk);
         send(av, bv, opv);
      end
      rdy_mode = 0;
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
